mac_overlay_scheduler: RTL and testbench
========================================

MAC_OVERLAY_SCHEDULER -- requirements
Module: mac_overlay_scheduler

Interface
REQ-001 SHALL have parameter MULT_LAT, default 2, the number of register stages inside the overlay multiplier.
REQ-002 SHALL have parameter RES_DEPTH, default 2, the result buffer depth.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 job_valid / job_ready  input / output  1 / 1  job handshake.
REQ-006 job_len  input  8  number of terms minus 1, so 0 means 1 term and 255 means 256 terms.
REQ-007 job_mode, job_a_sign, job_b_sign  input  1 each  job configuration.
REQ-008 op_valid / op_ready  input / output  1 / 1  operand handshake.
REQ-009 op_a, op_b  input  54 each  operand pair.
REQ-010 ovl_a, ovl_b  output  54 each  registered operands to the overlay.
REQ-011 ovl_mode, ovl_a_sign, ovl_b_sign  output  1 each  registered overlay configuration.
REQ-012 ovl_result_2  output  45  overlay X input.
REQ-013 ovl_cin  output  1  overlay carry-in; always 0.
REQ-014 ovl_s  input  45  overlay S_reg.
REQ-015 ovl_carry  input  4  overlay SIMD carry-out register.
REQ-016 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-017 res_data / res_carry  output  45 / 4  accumulated sum and lane carries.
REQ-018 busy  output  1  high whenever not IDLE or any tag is in flight.

Function
REQ-019 Issue latency SHALL be L = MULT_LAT+2: a term registered onto ovl_a/ovl_b at edge t contributes to ovl_s after edge t+L.
REQ-020 The FSM SHALL have three states: IDLE, DRAIN and RUN.
REQ-021 In IDLE with job_valid high and outstanding < RES_DEPTH, the block SHALL assert job_ready, where outstanding = buffered results + accepted jobs not yet captured.
REQ-022 On job accept with job_mode equal to ovl_mode, or with no tags in flight, the block SHALL load the configuration and go to RUN.
REQ-023 On job accept with job_mode differing from ovl_mode while tags are in flight, the block SHALL go to DRAIN.
REQ-024 DRAIN SHALL hold until the tag pipeline is empty, then load the configuration and go to RUN; the mode SHALL never change while a tag is in flight.
REQ-025 RUN SHALL assert op_ready every cycle.
REQ-026 In RUN, each op handshake SHALL register the operands and push tag {valid, first, last}, and the term counter SHALL decrement.
REQ-027 In RUN, a cycle without an op handshake SHALL register ovl_a = ovl_b = 0 and push an invalid tag (bubble).
REQ-028 After the last term is issued, the FSM SHALL return to IDLE; a next job with the same mode MAY issue on the following cycle.
REQ-029 The tag pipeline SHALL be L-1 deep and aligned so that its head is the term whose products are at the ALU W/Y inputs.
REQ-030 ovl_result_2 SHALL be 0 when the head tag is valid and first, and ovl_s otherwise (running accumulation; bubbles hold the sum).
REQ-031 One cycle after a head tag with last set, the block SHALL push {ovl_s, ovl_carry} into the result FIFO.
REQ-032 The accumulation SHALL use the overlay's native width and lanes: 45-bit wrap in mode 0 and per-lane wrap in mode 1, with no saturation.
REQ-033 The result FIFO SHALL never overflow; admission control (REQ-021) guarantees this, and result backpressure SHALL never stall the overlay pipeline.
REQ-034 On reset mid-operation, all in-flight tags and partial sums SHALL be discarded.

Reset
REQ-035 On reset: state=IDLE, tags and counters cleared, FIFO emptied.
REQ-036 On reset: job_ready=op_ready=res_valid=busy=0.
REQ-037 On reset: ovl_a/ovl_b/ovl_result_2/res_data=0, res_carry=0, ovl_mode/ovl_a_sign/ovl_b_sign=0, ovl_cin=0.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, the tag struct, and the width constants A_W=54, S_W=45, CARRY_W=4.
REQ-039 The result buffer SHALL be one sub-module, sched_result_fifo (parameterised depth, synchronous FIFO).
REQ-040 The bench SHALL connect the block to the overlay, with the overlay sharing clk and reset.

Verification
REQ-041 Mode 0, unsigned, job_len=2, three terms of a=3, b=4 back-to-back -> res_data=36, res_valid rises at edge t_last+L+1 (t_last+5 for MULT_LAT=2).
REQ-042 Signed (both signs=1), job_len=1, terms (-5,7) and (-5,7) -> res_data=-70 as a 45-bit two's-complement value.
REQ-043 job_len=3 with op_valid low for 2 cycles mid-job, terms 1x1, 2x2, 3x3, 4x4 -> res_data=30; bubbles do not alter the sum.
REQ-044 Job mode 0 immediately followed by job mode 1 -> FSM enters DRAIN, ovl_mode stays 0 until the tags are empty, and both results are correct and in order.
REQ-045 res_ready=0 and three single-term jobs offered -> the third job_ready stays low until one res_ready pop; no result is lost.
REQ-046 Reset asserted in RUN with 2 tags in flight -> no res_valid afterwards; a fresh job then yields the correct sum.

Source files
------------

// File: rtl/mac_overlay_scheduler_pkg.sv
// Shared types and widths for the MAC overlay scheduler.
//   A_W      operand width fed to the overlay multiplier
//   S_W      accumulator (S_reg) width of the overlay ALU
//   CARRY_W  SIMD lane carry-out width
//   state_t  scheduler FSM states
//   tag_t    per-term tag that travels alongside the overlay pipeline
package mac_overlay_scheduler_pkg;

  localparam int A_W     = 54;
  localparam int S_W     = 45;
  localparam int CARRY_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/sched_result_fifo.sv
// Synchronous result FIFO for the MAC overlay scheduler.
//   clk, reset     clock, synchronous active-high reset (empties the FIFO)
//   push, din      write side; a push into a full FIFO is dropped
//   pop            read side; ignored when empty
//   dout, valid    head entry and non-empty flag
module sched_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 49
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign valid   = (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mac_overlay_scheduler.sv
// Feeds multiply-accumulate jobs into a pipelined MAC overlay and collects
// the accumulated sums.
//   job_*   job handshake: term count minus one, SIMD mode, operand signs
//   op_*    operand-pair handshake, one pair per term
//   ovl_*   registered operands/config to the overlay, X input (ovl_result_2),
//           carry-in, and the overlay's S_reg / lane carries coming back
//   res_*   result handshake: accumulated sum and lane carries
//   busy    FSM not idle or terms still travelling through the overlay
module mac_overlay_scheduler
  import mac_overlay_scheduler_pkg::*;
#(
  parameter int MULT_LAT  = 2,
  parameter int RES_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [7:0]         job_len,
  input  logic               job_mode,
  input  logic               job_a_sign,
  input  logic               job_b_sign,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [A_W-1:0]     op_a,
  input  logic [A_W-1:0]     op_b,
  output logic [A_W-1:0]     ovl_a,
  output logic [A_W-1:0]     ovl_b,
  output logic               ovl_mode,
  output logic               ovl_a_sign,
  output logic               ovl_b_sign,
  output logic [S_W-1:0]     ovl_result_2,
  output logic               ovl_cin,
  input  logic [S_W-1:0]     ovl_s,
  input  logic [CARRY_W-1:0] ovl_carry,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [S_W-1:0]     res_data,
  output logic [CARRY_W-1:0] res_carry,
  output logic               busy
);

  // Operands registered at edge t reach S_reg after edge t+L. The issue tag
  // sits beside ovl_a/ovl_b; the L-1 deep pipe behind it puts its head on the
  // term whose product is at the ALU W/Y inputs.
  localparam int L          = MULT_LAT + 2;
  localparam int TAG_STAGES = L - 1;
  localparam int OUT_W      = $clog2(RES_DEPTH + 1);

  state_t                    state;
  logic [7:0]                term_cnt;
  logic                      first_q;
  logic                      pend_mode, pend_a_sign, pend_b_sign;
  tag_t                      issue_tag;
  tag_t [TAG_STAGES-1:0]     tag_pipe;
  tag_t                      head;
  logic                      last_d;
  logic [OUT_W-1:0]          outstanding;
  logic                      tags_busy;
  logic                      job_accept, op_fire, res_pop;

  assign head       = tag_pipe[TAG_STAGES-1];
  assign job_ready  = (state == IDLE) && job_valid && (outstanding < OUT_W'(RES_DEPTH));
  assign op_ready   = (state == RUN);
  assign job_accept = job_valid && job_ready;
  assign op_fire    = op_valid && op_ready;
  assign res_pop    = res_valid && res_ready;
  assign ovl_cin    = 1'b0;
  assign busy       = (state != IDLE) || tags_busy || last_d;

  // First term of a job starts from zero; everything else (including bubbles,
  // whose product is zero) accumulates onto S_reg.
  assign ovl_result_2 = (head.valid && head.first) ? '0 : ovl_s;

  always_comb begin
    tags_busy = issue_tag.valid;
    for (int i = 0; i < TAG_STAGES; i++) tags_busy = tags_busy | tag_pipe[i].valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      term_cnt    <= '0;
      first_q     <= 1'b0;
      pend_mode   <= 1'b0;
      pend_a_sign <= 1'b0;
      pend_b_sign <= 1'b0;
      issue_tag   <= TAG_NONE;
      tag_pipe    <= '0;
      last_d      <= 1'b0;
      outstanding <= '0;
      ovl_a       <= '0;
      ovl_b       <= '0;
      ovl_mode    <= 1'b0;
      ovl_a_sign  <= 1'b0;
      ovl_b_sign  <= 1'b0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < TAG_STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
      last_d <= head.valid && head.last;
      // Counts a job from acceptance until its result leaves the FIFO, so
      // admission alone keeps the FIFO from overflowing.
      outstanding <= outstanding + OUT_W'(job_accept) - OUT_W'(res_pop);

      ovl_a     <= '0;
      ovl_b     <= '0;
      issue_tag <= TAG_NONE;

      case (state)
        IDLE: begin
          if (job_accept) begin
            term_cnt <= job_len;
            first_q  <= 1'b1;
            // The ALU mode must not change under a term still in flight.
            if ((job_mode == ovl_mode) || !tags_busy) begin
              ovl_mode   <= job_mode;
              ovl_a_sign <= job_a_sign;
              ovl_b_sign <= job_b_sign;
              state      <= RUN;
            end else begin
              pend_mode   <= job_mode;
              pend_a_sign <= job_a_sign;
              pend_b_sign <= job_b_sign;
              state       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!tags_busy) begin
            ovl_mode   <= pend_mode;
            ovl_a_sign <= pend_a_sign;
            ovl_b_sign <= pend_b_sign;
            state      <= RUN;
          end
        end
        RUN: begin
          if (op_fire) begin
            ovl_a     <= op_a;
            ovl_b     <= op_b;
            issue_tag <= '{valid: 1'b1, first: first_q, last: (term_cnt == 8'd0)};
            first_q   <= 1'b0;
            if (term_cnt == 8'd0) state <= IDLE;
            else                  term_cnt <= term_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The sum is final in S_reg the cycle after its last term left the ALU.
  sched_result_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (S_W + CARRY_W)
  ) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (last_d),
    .din   ({ovl_s, ovl_carry}),
    .pop   (res_pop),
    .dout  ({res_data, res_carry}),
    .valid (res_valid)
  );

endmodule

// File: tb/tb_mac_overlay_scheduler.sv
// Directed bench: the scheduler drives a behavioural MAC overlay model that
// shares clk/reset; result sums are hand-computed constants.
module tb_mac_overlay_scheduler;
  import mac_overlay_scheduler_pkg::*;

  localparam int MULT_LAT = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               job_valid = 1'b0, job_ready;
  logic [7:0]         job_len = '0;
  logic               job_mode = 1'b0, job_a_sign = 1'b0, job_b_sign = 1'b0;
  logic               op_valid = 1'b0, op_ready;
  logic [A_W-1:0]     op_a = '0, op_b = '0;
  logic [A_W-1:0]     ovl_a, ovl_b;
  logic               ovl_mode, ovl_a_sign, ovl_b_sign, ovl_cin;
  logic [S_W-1:0]     ovl_result_2, ovl_s;
  logic [CARRY_W-1:0] ovl_carry;
  logic               res_valid, res_ready = 1'b0;
  logic [S_W-1:0]     res_data;
  logic [CARRY_W-1:0] res_carry;
  logic               busy;

  int tests = 0, fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_overlay_scheduler #(.MULT_LAT(MULT_LAT), .RES_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .job_mode(job_mode), .job_a_sign(job_a_sign), .job_b_sign(job_b_sign),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .ovl_a(ovl_a), .ovl_b(ovl_b), .ovl_mode(ovl_mode),
    .ovl_a_sign(ovl_a_sign), .ovl_b_sign(ovl_b_sign),
    .ovl_result_2(ovl_result_2), .ovl_cin(ovl_cin),
    .ovl_s(ovl_s), .ovl_carry(ovl_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .busy(busy)
  );

  // ---------------- overlay model ----------------
  // Input regs are the scheduler's ovl_a/ovl_b; MULT_LAT multiplier stages,
  // an M register, then S_reg = X + M.
  logic signed [54:0]  ax, bx;
  logic signed [109:0] prod;
  logic [S_W-1:0]      p_pipe [MULT_LAT];
  logic [S_W-1:0]      m_reg;

  assign ax   = {ovl_a_sign & ovl_a[53], ovl_a};
  assign bx   = {ovl_b_sign & ovl_b[53], ovl_b};
  assign prod = ax * bx;

  function automatic logic [48:0] alu(input logic [44:0] x, input logic [44:0] y, input logic mode);
    logic [45:0] t;
    logic [11:0] ln;
    logic [44:0] s;
    logic [3:0]  c;
    s = '0;
    c = '0;
    if (!mode) begin
      t = {1'b0, x} + {1'b0, y};
      s = t[44:0];
      c = {t[45], 3'b000};
    end else begin
      for (int i = 0; i < 4; i++) begin
        ln = {1'b0, x[11*i +: 11]} + {1'b0, y[11*i +: 11]};
        s[11*i +: 11] = ln[10:0];
        c[i] = ln[11];
      end
    end
    return {c, s};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MULT_LAT; k++) p_pipe[k] <= '0;
      m_reg     <= '0;
      ovl_s     <= '0;
      ovl_carry <= '0;
    end else begin
      p_pipe[0] <= prod[44:0];
      for (int k = 1; k < MULT_LAT; k++) p_pipe[k] <= p_pipe[k-1];
      m_reg <= p_pipe[MULT_LAT-1];
      {ovl_carry, ovl_s} <= alu(ovl_result_2, m_reg, ovl_mode);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input string tag, input logic mode, input logic as, input logic bs,
                          input logic [7:0] len);
    int n = 0;
    logic ok;
    job_mode = mode; job_a_sign = as; job_b_sign = bs; job_len = len; job_valid = 1'b1;
    #1;
    while (!job_ready && n < 40) begin tick(); n++; end
    ok = job_ready;
    if (ok) tick();
    job_valid = 1'b0;
    check({tag, " job accept"}, ok, 1);
  endtask

  task automatic send_op(input string tag, input logic [53:0] a, input logic [53:0] b);
    int n = 0;
    logic ok;
    op_a = a; op_b = b; op_valid = 1'b1;
    #1;
    while (!op_ready && n < 40) begin tick(); n++; end
    ok = op_ready;
    if (ok) tick();
    op_valid = 1'b0;
    check({tag, " op accept"}, ok, 1);
  endtask

  task automatic expect_res(input string tag, input logic [44:0] exp);
    int n = 0;
    while (!res_valid && n < 40) begin tick(); n++; end
    check({tag, " valid"}, res_valid, 1);
    check(tag, res_data, exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_last, n;
    logic seen, mode_ok;

    repeat (3) tick();
    check("rst job_ready", job_ready, 0);
    check("rst op_ready", op_ready, 0);
    check("rst res_valid", res_valid, 0);
    check("rst busy", busy, 0);
    check("rst ovl_a", ovl_a, 0);
    check("rst ovl_result_2", ovl_result_2, 0);
    check("rst res_data", res_data, 0);
    check("rst ovl_mode", ovl_mode, 0);
    check("rst ovl_cin", ovl_cin, 0);
    reset = 1'b0;
    tick();

    // Three back-to-back 3x4 terms; result latency from the last issue.
    send_job("j36", 0, 0, 0, 8'd2);
    check("run op_ready", op_ready, 1);
    check("run busy", busy, 1);
    send_op("j36a", 3, 4);
    send_op("j36b", 3, 4);
    send_op("j36c", 3, 4);
    t_last = cyc;
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    check("res latency", 64'(cyc - t_last), 5);
    check("j36 carry", res_carry, 0);
    expect_res("j36 sum", 45'd36);

    // Signed (-5)*7 twice.
    send_job("jneg", 0, 1, 1, 8'd1);
    send_op("jneg a", 54'd0 - 54'd5, 54'd7);
    send_op("jneg b", 54'd0 - 54'd5, 54'd7);
    expect_res("jneg sum", 45'd0 - 45'd70);

    // Two-cycle op gap mid-job.
    send_job("jgap", 0, 0, 0, 8'd3);
    send_op("jgap 1", 1, 1);
    tick();
    check("bubble ovl_a", ovl_a, 0);
    check("bubble ovl_b", ovl_b, 0);
    check("bubble op_ready", op_ready, 1);
    tick();
    send_op("jgap 2", 2, 2);
    send_op("jgap 3", 3, 3);
    send_op("jgap 4", 4, 4);
    expect_res("jgap sum", 45'd30);

    // Mode change right behind an in-flight term.
    send_job("jm0", 0, 0, 0, 8'd0);
    send_op("jm0", 3, 4);
    send_job("jm1", 1, 0, 0, 8'd0);
    check("drain state", dut.state, DRAIN);
    check("drain ovl_mode", ovl_mode, 0);
    check("drain op_ready", op_ready, 0);
    check("drain busy", busy, 1);
    mode_ok = 1'b1;
    n = 0;
    while (!op_ready && n < 20) begin
      if (ovl_mode !== 1'b0) mode_ok = 1'b0;
      tick();
      n++;
    end
    check("drain mode held", mode_ok, 1);
    check("post-drain ovl_mode", ovl_mode, 1);
    send_op("jm1", 5, 6);
    expect_res("jm0 sum", 45'd12);
    check("jm1 carry", res_carry, 0);
    expect_res("jm1 sum", 45'd30);

    // Result backpressure: third job held off until a pop.
    send_job("bp1", 0, 0, 0, 8'd0);
    send_op("bp1", 1, 2);
    send_job("bp2", 0, 0, 0, 8'd0);
    send_op("bp2", 3, 3);
    job_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (job_ready) seen = 1'b1;
    end
    check("bp3 held off", seen, 0);
    expect_res("bp1 sum", 45'd2);
    send_job("bp3", 0, 0, 0, 8'd0);
    send_op("bp3", 2, 5);
    expect_res("bp2 sum", 45'd9);
    expect_res("bp3 sum", 45'd10);

    // Reset with two terms in flight.
    send_job("jrst", 0, 0, 0, 8'd4);
    send_op("jrst a", 7, 7);
    send_op("jrst b", 8, 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid-rst busy", busy, 0);
    check("mid-rst op_ready", op_ready, 0);
    check("mid-rst res_valid", res_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    check("no stale result", seen, 0);
    send_job("jfresh", 0, 0, 0, 8'd1);
    send_op("jfresh a", 2, 3);
    send_op("jfresh b", 4, 5);
    expect_res("jfresh sum", 45'd26);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
